key_press_decoder: RTL and testbench

Consumer of the debounced key level produced by the key debouncer in the clock (shizhong) design. It classifies each press of one key into an event: short press, long press, auto-repeat while held, and optionally double-click. Time/alarm setting logic uses these single-cycle event pulses instead of raw key edges.

---
 rtl/key_pkg.sv | 28 ++
 rtl/key_press_decoder.sv | 146 ++++++++++++++
 tb/tb_key_press_decoder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared types and 50 MHz default timings for the key press decoder.
// Used by key_press_decoder; see that file for the KEY_DOUBLE_CLICK_EN build option.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
    HOLD,
    GAP,
    WAIT_REL
  } state_t;

  localparam int LONG_CNT_DEF    = 50_000_000;
  localparam int REPEAT_CNT_DEF  = 10_000_000;
  localparam int DBL_GAP_CNT_DEF = 15_000_000;
  localparam int CNT_W_DEF       = 26;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_press_decoder.sv
// Classifies debounced key presses into short/long/repeat pulses.
// Define KEY_DOUBLE_CLICK_EN to build the GAP/WAIT_REL double-click path.
module key_press_decoder
  import key_pkg::*;
#(
  parameter int LONG_CNT    = LONG_CNT_DEF,
  parameter int REPEAT_CNT  = REPEAT_CNT_DEF,
  parameter int DBL_GAP_CNT = DBL_GAP_CNT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_state,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic double_click,
  output logic key_held
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_TOP   =
    CNT_W'(max3(LONG_CNT, REPEAT_CNT, DBL_GAP_CNT));
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
`ifdef KEY_DOUBLE_CLICK_EN
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_CNT - 1);
`endif

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
  logic             key_d;
  logic             short_nx, long_nx, rep_nx, dbl_nx, held_nx;

  // Saturate so the shared counter can never wrap past its range
  assign cnt_inc = (cnt == CNT_TOP) ? cnt : cnt + ONE;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    short_nx = 1'b0;
    long_nx  = 1'b0;
    rep_nx   = 1'b0;
    dbl_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (key_d && !key_state) begin
          state_nx = PRESS;
          cnt_nx   = ONE;
        end
      end
      PRESS: begin
        if (!key_state) begin
          if (cnt == LONG_LAST) begin
            long_nx  = 1'b1;
            state_nx = HOLD;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt_inc;
          end
        end else begin
`ifdef KEY_DOUBLE_CLICK_EN
          state_nx = GAP;
          cnt_nx   = ONE;
`else
          short_nx = 1'b1;
          state_nx = IDLE;
          cnt_nx   = '0;
`endif
        end
      end
      HOLD: begin
        if (key_state) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == REP_LAST) begin
          rep_nx = 1'b1;
          cnt_nx = '0;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
`ifdef KEY_DOUBLE_CLICK_EN
      GAP: begin
        if (!key_state) begin
          dbl_nx   = 1'b1;
          state_nx = WAIT_REL;
          cnt_nx   = '0;
        end else if (cnt == GAP_LAST) begin
          short_nx = 1'b1;
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      WAIT_REL: begin
        if (key_state) begin
          state_nx = IDLE;
        end
      end
`endif
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign held_nx = (state_nx == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      key_d        <= 1'b1;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      key_held     <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      key_d        <= key_state;
      short_press  <= short_nx;
      long_press   <= long_nx;
      repeat_pulse <= rep_nx;
      key_held     <= held_nx;
    end
  end

`ifdef KEY_DOUBLE_CLICK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      double_click <= 1'b0;
    end else begin
      double_click <= dbl_nx;
    end
  end
`else
  assign double_click = 1'b0;
  logic unused_dbl;
  assign unused_dbl = dbl_nx;
`endif

endmodule

// File: tb/tb_key_press_decoder.sv
// Directed vector bench for key_press_decoder (LONG=8, REPEAT=4, GAP=6).
// Feature-specific vectors follow KEY_DOUBLE_CLICK_EN.
module tb_key_press_decoder;

  localparam int LC = 8;
  localparam int RC = 4;
  localparam int GC = 6;
  localparam int CW = 4;

  // Output vector order: {short, long, repeat, double, held}
  localparam logic [4:0] S   = 5'b10000;
  localparam logic [4:0] L   = 5'b01000;
  localparam logic [4:0] R   = 5'b00100;
  localparam logic [4:0] D   = 5'b00010;
  localparam logic [4:0] H   = 5'b00001;
  localparam logic [4:0] Z   = 5'b00000;
  localparam logic [4:0] ALL = 5'b11111;
  localparam logic [4:0] NOH = 5'b11110;

  logic clk = 1'b0;
  logic rst_n;
  logic key_state;
  logic short_press, long_press, repeat_pulse, double_click, key_held;

  always #5 clk = ~clk;

  key_press_decoder #(
    .LONG_CNT    (LC),
    .REPEAT_CNT  (RC),
    .DBL_GAP_CNT (GC),
    .CNT_W       (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_state    (key_state),
    .short_press  (short_press),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse),
    .double_click (double_click),
    .key_held     (key_held)
  );

  typedef struct {
    logic       key;
    logic [4:0] exp;
    logic [4:0] care;
    string      name;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [4:0] outs();
    return {short_press, long_press, repeat_pulse, double_click, key_held};
  endfunction

  task automatic check(input string n, input logic [4:0] act,
                       input logic [4:0] exp, input logic [4:0] care);
    checks++;
    if ((act & care) !== (exp & care)) begin
      errors++;
      $display("FAIL %s: got %b want %b (mask %b) at %0t",
               n, act, exp, care, $time);
    end
  endtask

  task automatic check_int(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask

  task automatic add(input logic k, input logic [4:0] e,
                     input logic [4:0] c, input string n);
    vec_t v;
    v.key  = k;
    v.exp  = e;
    v.care = c;
    v.name = n;
    tbl.push_back(v);
  endtask

  task automatic add_run(input logic k, input logic [4:0] e,
                         input logic [4:0] c, input string n,
                         input int count);
    for (int i = 0; i < count; i++) add(k, e, c, n);
  endtask

  int  long_at;
  bit  spurious;

  initial begin
    rst_n     = 1'b0;
    key_state = 1'b1;

    add_run(1, Z, ALL, "idle", 2);
`ifdef KEY_DOUBLE_CLICK_EN
    // double-click: low 2, high 3, low 2, high
    add_run(0, Z, ALL, "dc_low1", 2);
    add_run(1, Z, ALL, "dc_gap", 3);
    add(0, D, ALL, "dc_pulse");
    add(0, Z, ALL, "dc_low2");
    add(1, Z, ALL, "dc_rel");
    add_run(1, Z, ALL, "dc_after", 7);
    // single click delayed by gap window
    add_run(0, Z, ALL, "sc_low", 2);
    add_run(1, Z, ALL, "sc_gap", 5);
    add(1, S, ALL, "sc_short");
    add(1, Z, ALL, "sc_after");
`else
    add_run(0, Z, ALL, "t1_low", 3);
    add(1, S, ALL, "t1_short");
    add(1, Z, ALL, "t1_after");
    add_run(0, Z, ALL, "t2_low7", 7);
    add(1, S, ALL, "t2_short7");
    add(1, Z, ALL, "t2_after7");
`endif
    add_run(0, Z, ALL, "t2_low8", 7);
    add(0, L, NOH, "t2_long8");
    add(1, Z, NOH, "t2_rel8");
    add_run(1, Z, ALL, "t2_noshort", 8);

    add_run(0, Z, ALL, "t3_low", 7);
    add(0, L, NOH, "t3_long");
    add_run(0, H, ALL, "t3_hold_a", 3);
    add(0, R | H, ALL, "t3_rep12");
    add_run(0, H, ALL, "t3_hold_b", 3);
    add(0, R | H, ALL, "t3_rep16");
    add(1, Z, NOH, "t3_rel");
    add_run(1, Z, ALL, "t3_idle", 3);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs(), Z, ALL);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      key_state = tbl[i].key;
      @(posedge clk);
      #1;
      check(tbl[i].name, outs(), tbl[i].exp, tbl[i].care);
    end

    // async reset in the middle of HOLD with key still low
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      key_state = 1'b0;
      @(posedge clk);
      #1;
    end
    check("t6_held_before", outs(), H, ALL);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_async_rst", outs(), Z, ALL);
    @(negedge clk);
    rst_n = 1'b1;

    long_at  = 0;
    spurious = 1'b0;
    for (int i = 1; i <= 20 && long_at == 0; i++) begin
      @(posedge clk);
      #1;
      if (short_press || repeat_pulse || double_click) spurious = 1'b1;
      if (long_press) long_at = i;
    end
    check_int("t6_long_after_rst", long_at, LC);
    check_int("t6_no_other_pulse", int'(spurious), 0);

    @(negedge clk);
    key_state = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rel", outs(), Z, NOH);
    @(posedge clk);
    #1;
    check("t6_idle", outs(), Z, ALL);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
